shift_register_n: RTL
=====================

Name: shift_register_n

Overview:
Parametrised successor to the fixed 9-tap filter shift register in the convolver. It holds DEPTH words of WIDTH bits and exposes every tap in parallel to the MAC array.
- Adds a valid/ready input handshake, a saturating fill counter, window-full status and a one-cycle "window filled" pulse.
- Adds a synchronous clear for flushing between filters or channels.

Parameters:
WIDTH, 16, bits per tap; matches `WID_FILTER.
DEPTH, 9, number of taps (≥2).
CNT_W, $clog2(DEPTH+1), width of the fill counter (derived; not overridden).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
clear  in  1  synchronous flush of taps and fill count.
hold  in  1  consumer freeze; blocks shifting.
in_valid  in  1  in_data is valid this cycle.
in_ready  out  1  block can accept this cycle.
in_data  in  WIDTH  new word; enters tap 0.
taps  out  DEPTH*WIDTH  flattened taps; tap i at [i*WIDTH +: WIDTH]; tap 0 newest.
fill_cnt  out  CNT_W  words held, saturating at DEPTH.
full  out  1  fill_cnt == DEPTH.
filled  out  1  one-cycle pulse on the cycle after fill_cnt reaches DEPTH.

Behaviour:
- Reset (async, rst=1): taps=0, fill_cnt=0, full=0, filled=0. in_ready is combinational and is 1 once rst and clear are low and hold=0.
- in_ready = ~hold & ~clear & ~rst. accept = in_valid & in_ready.
- On accept, all at the same edge: tap[0]<=in_data and tap[i]<=tap[i-1] for i=1..DEPTH-1. The oldest word drops out of tap[DEPTH-1].
- Latency: a word accepted at edge k is visible on tap 0 after edge k and on tap j after j further accepts.
- No accept: all taps hold their values. hold stalls only; it never alters contents.
- fill_cnt increments on accept while < DEPTH and saturates at DEPTH. Shifting continues when full (sliding window).
- full is registered and equals (fill_cnt==DEPTH).
- filled is registered. It is 1 for exactly one cycle after the accept that takes fill_cnt from DEPTH-1 to DEPTH, and does not repeat while saturated.
- clear=1 at an edge: taps=0, fill_cnt=0, full=0, filled=0. clear has priority over accept. Because in_ready is low during clear, no word is lost silently.
- A clear on the same edge where filled would rise suppresses filled.
- rst asserted mid-operation clears everything immediately. Operation resumes from empty on the first edge after deassertion.
- No arithmetic beyond the counter. Taps are pass-through, with no sign handling.

Optional Feature:
Macro SHIFT_REG_ROTATE_EN.
- Defined:
  - Adds input port `rotate` (1 bit).
  - When rotate=1, full=1, hold=0, clear=0 and no accept: circular shift, tap[0]<=tap[DEPTH-1], tap[i]<=tap[i-1]. fill_cnt, full and filled are unchanged.
  - Accept has priority over rotate. Rotate while not full is ignored.
  - Purpose: reusing loaded weights across output positions without a reload.
- Not defined: no rotate port, and taps change only on accept, clear or reset.

Decomposition:
- Shared package conv_pkg holds:
  - localparam WID_FILTER_P (=16).
  - typedef logic [WID_FILTER_P-1:0] filt_word_t.
  - The default tap depth constant FILT_TAPS (=9).
- One sub-module, sr_tap_reg: a single WIDTH-bit register with async reset, sync clear and load enable. It is instantiated DEPTH times via generate, with the next-value mux (shift, rotate or hold) in the parent.
- The counter and flags live in the parent.

Test Plan:
- Reset, then feed 1..9 with in_valid=1, hold=0 (WIDTH=16, DEPTH=9) -> after the 9th accept tap0=9 … tap8=1, fill_cnt=9, full=1, and filled high for exactly one cycle.
- Continue with 10 and 11 -> tap0=11, tap8=3, fill_cnt stays 9, filled stays 0.
- hold=1 for 3 cycles with in_valid=1 and data 0xAAAA -> in_ready=0 and taps unchanged. On hold=0, 0xAAAA enters tap0.
- Assert clear together with in_valid at fill_cnt=8 -> the next cycle shows taps all 0, fill_cnt=0, full=0 and no filled pulse. The simultaneous word is not accepted.
- Assert rst asynchronously mid-stream (between edges) -> all outputs go to 0 before the next edge. Refilling with 9 words produces filled again.
- With SHIFT_REG_ROTATE_EN, full with taps 9..1, rotate=1 for 1 cycle -> tap0=1, tap1=9, tap8=2 and fill_cnt=9. rotate plus in_valid -> shift wins.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared convolver constants and types.
// Default filter word width and tap depth.
package conv_pkg;

  localparam int WID_FILTER_P = 16;
  localparam int FILT_TAPS = 9;

  typedef logic [WID_FILTER_P-1:0] filt_word_t;

endpackage

// File: rtl/sr_tap_reg.sv
// Single tap register of the filter window.
// Async reset, sync clear, load enable.
module sr_tap_reg
  import conv_pkg::*;
#(
  parameter int WIDTH = WID_FILTER_P
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_d;
  logic [WIDTH-1:0] val_q;

  // clear beats load; otherwise hold
  always_comb begin
    val_d = val_q;
    if (clear) begin
      val_d = '0;
    end else if (load) begin
      val_d = d;
    end
  end

  // tap storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/shift_register_n.sv
// Parametrised tap window with valid/ready input.
// Optional circular rotate: SHIFT_REG_ROTATE_EN.
module shift_register_n
  import conv_pkg::*;
#(
  parameter int WIDTH = WID_FILTER_P,
  parameter int DEPTH = FILT_TAPS,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   hold,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic                   rotate,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic [DEPTH*WIDTH-1:0] taps,
  output logic [CNT_W-1:0]       fill_cnt,
  output logic                   full,
  output logic                   filled
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DEPTH - 1);

  logic             accept;
  logic             rotate_go;
  logic             load;
  logic [WIDTH-1:0] tap_d [DEPTH];
  logic [WIDTH-1:0] tap_q [DEPTH];

  logic [CNT_W-1:0] fill_cnt_d;
  logic [CNT_W-1:0] fill_cnt_q;
  logic             full_d;
  logic             full_q;
  logic             filled_d;
  logic             filled_q;

  assign in_ready = ~hold & ~clear & ~rst;
  assign accept = in_valid & in_ready;

`ifdef SHIFT_REG_ROTATE_EN
  assign rotate_go = rotate & full_q & ~hold
                   & ~clear & ~accept;
`else
  assign rotate_go = 1'b0;
`endif

  assign load = accept | rotate_go;

  // next tap values: new word or wrap into tap 0
  always_comb begin
    tap_d[0] = accept ? in_data : tap_q[DEPTH-1];
    for (int i = 1; i < DEPTH; i++) begin
      tap_d[i] = tap_q[i-1];
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_tap
      sr_tap_reg #(
        .WIDTH(WIDTH)
      ) u_tap (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .load (load),
        .d    (tap_d[g]),
        .q    (tap_q[g])
      );
      assign taps[g*WIDTH +: WIDTH] = tap_q[g];
    end
  endgenerate

  // saturating fill count and window flags
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    filled_d = 1'b0;
    if (clear) begin
      fill_cnt_d = '0;
    end else if (accept) begin
      if (fill_cnt_q != DEPTH_C) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
      filled_d = (fill_cnt_q == LAST_C);
    end
    full_d = (fill_cnt_d == DEPTH_C);
  end

  // counter and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt_q <= '0;
      full_q <= 1'b0;
      filled_q <= 1'b0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      full_q <= full_d;
      filled_q <= filled_d;
    end
  end

  assign fill_cnt = fill_cnt_q;
  assign full = full_q;
  assign filled = filled_q;

endmodule
